aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Control FSM for the AES-128/192/256 encryption datapath. It steps the round primitives (addRoundKey, subBytes, shiftRows, mixColumns) in the standard FIPS-197 order. For each step it issues a request/acknowledge handshake to the selected primitive and drives the round-key index to the key-expansion store. It owns no state data; it only sequences and counts, and sits between the top-level encrypt command and the per-step datapath units.

## Interface
Parameters:
- NUM_ROUNDS, 10, number of AES rounds Nr; legal values 10, 12, 14 (others unsupported).
- TIMEOUT_CYCLES, 255, maximum REQ cycles per step before abort. Used only with AES_STEP_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin one encryption; sampled only in IDLE.
- abort  in  1  synchronous cancel; honoured in any non-IDLE state.
- step_ack  in  1  one-cycle completion pulse from the selected primitive.
- step_req  out  1  level request to the primitive selected by step_sel.
- step_sel  out  2  0=addRoundKey, 1=subBytes, 2=shiftRows, 3=mixColumns.
- key_idx  out  4  round-key index 0..NUM_ROUNDS (16-byte word offset into expanded key).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of sequence.
- err  out  1  valid with done; 1 = sequence terminated by timeout.

## Operation
- Reset: state=IDLE. step_req, step_sel, key_idx, busy, done, err all 0. Round counter 0. Timeout counter 0.
- States: IDLE, REQ, ADV, FIN.
- Step order, per round r:
  - r=0: ARK.
  - r=1..Nr-1: SB, SR, MC, ARK.
  - r=Nr: SB, SR, ARK (no MC).
  - Total steps S = 4*Nr (40 for Nr=10).
- key_idx = r for every step of round r; it only matters during ARK but is driven throughout.
- IDLE: on start=1, load r=0, step=ARK, go to REQ. busy rises.
- REQ: step_req=1. step_sel and key_idx are held stable. On step_ack=1 go to ADV.
- ADV: step_req=0. Compute next step/round. If the final ARK of round Nr just finished, go to FIN; else go to REQ.
- FIN: done=1, busy=0, step_req=0. Go to IDLE next cycle.
- start while not in IDLE is ignored; no queuing.
- step_ack outside REQ is ignored.
- abort=1 in REQ/ADV: go to IDLE next edge with step_req=0, busy=0, no done, counters cleared. abort in FIN: done still pulses.
- abort and step_ack in the same cycle: abort wins.
- rst asserted mid-sequence: outputs clear immediately (asynchronous); no done.

## Timing
- start sampled at edge E0. step_req is high in the cycle following E0.
- step_ack is registered by the primitive and arrives no earlier than the second REQ cycle.
- Minimum step cost: 2 REQ cycles + 1 ADV cycle = 3 cycles.
- With minimum-latency acks, done is high 3*S cycles after E0 (120 for Nr=10, 144 for Nr=12, 168 for Nr=14).
- step_req always deasserts for exactly one cycle (ADV) between consecutive steps.
- step_sel and key_idx change only in ADV.
- done is high for exactly one cycle. busy falls in the same cycle done rises.
- A new start is accepted in the cycle after done (first IDLE cycle).

## Configuration
- AES_STEP_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter increments each REQ cycle and clears on entry to REQ.
  - If it reaches TIMEOUT_CYCLES with no ack, go to FIN with err=1. done pulses, and err stays high for that done cycle only.
- AES_STEP_TIMEOUT_EN undefined:
  - No counter is built; REQ waits indefinitely.
  - err is tied 0.

## Test plan
- Nr=10, primitive acks in second REQ cycle: start -> 40 handshakes in order ARK(0), then SB,SR,MC,ARK for key_idx 1..9, then SB,SR,ARK(10). done at cycle 120, err=0.
- Nr=14, ack delays random 1..7 cycles: MC issued exactly 13 times. key_idx sequence 0..14 monotonic. done exactly once.
- start pulsed at step 5 and again at step 20 -> ignored. Sequence and done timing identical to the no-extra-start run.
- abort asserted together with ack on step 12 -> IDLE next cycle. No done, busy=0. A following start restarts at key_idx=0, ARK.
- rst low during REQ of round 6 -> all outputs 0 in the same cycle. After release, IDLE holds until start.
- AES_STEP_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack withheld on step 3 -> done with err=1 exactly 16 REQ cycles after step_req rose. err is 0 on the next normal run.

Source files
------------

// File: rtl/aes_round_sequencer_if.sv
// Step bus between the AES round sequencer and the round primitives: a level
// request with the selected primitive and round-key index, and a one-cycle ack back.
interface aes_round_sequencer_if;
    logic       step_req;
    logic       step_ack;
    logic [1:0] step_sel;
    logic [3:0] key_idx;

    modport master (output step_req, step_sel, key_idx, input step_ack);
    modport slave  (input step_req, step_sel, key_idx, output step_ack);
endinterface

// File: rtl/aes_round_sequencer.sv
// Sequencer for AES-128/192/256 rounds: steps ARK/SB/SR/MC in order, one handshake per step.
// Optional per-step REQ timeout when AES_STEP_TIMEOUT_EN is defined.
module aes_round_sequencer #(
    parameter int unsigned NUM_ROUNDS     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    aes_round_sequencer_if.master        step_bus,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    typedef enum logic [1:0] {StIdle, StReq, StAdv, StFin} state_e;
    typedef enum logic [1:0] {SelArk = 2'd0, SelSb = 2'd1, SelSr = 2'd2, SelMc = 2'd3} sel_e;

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    state_e     state_q, state_d;
    sel_e       sel_q, sel_d;
    logic [3:0] round_q, round_d;
    logic       req_q, req_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       tmo_hit;

`ifdef AES_STEP_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TmoW-1:0] tmo_q, tmo_d;

    // Fires in the REQ cycle that would be the TIMEOUT_CYCLES-th without an ack.
    assign tmo_hit = (({1'b0, tmo_q} + 1'b1) == (TmoW + 1)'(TIMEOUT_CYCLES));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        round_d = round_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReq;
                    sel_d   = SelArk;
                    round_d = '0;
                end
            end
            StReq: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (step_bus.step_ack) begin
                    state_d = StAdv;
                end else if (tmo_hit) begin
                    state_d = StFin;
                    err_d   = 1'b1;
                end
            end
            StAdv: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    state_d = StReq;
                    unique case (sel_q)
                        SelArk: begin
                            if (round_q == LastRound) begin
                                state_d = StFin;
                            end else begin
                                round_d = round_q + 4'd1;
                                sel_d   = SelSb;
                            end
                        end
                        SelSb: sel_d = SelSr;
                        // The final round skips mixColumns.
                        SelSr: sel_d = (round_q == LastRound) ? SelArk : SelMc;
                        SelMc: sel_d = SelArk;
                    endcase
                end
            end
            StFin: state_d = StIdle;
        endcase

        if (state_d == StIdle) begin
            sel_d   = SelArk;
            round_d = '0;
        end

        req_d  = (state_d == StReq);
        busy_d = (state_d == StReq) || (state_d == StAdv);
        done_d = (state_d == StFin);
    end

`ifdef AES_STEP_TIMEOUT_EN
    assign tmo_d = ((state_q == StReq) && (state_d == StReq)) ? tmo_q + 1'b1 : '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sel_q   <= SelArk;
            round_q <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef AES_STEP_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            round_q <= round_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef AES_STEP_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign step_bus.step_req = req_q;
    assign step_bus.step_sel = sel_q;
    assign step_bus.key_idx  = round_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: lane 0 runs Nr=10, lane 1 runs Nr=14.
module tb_aes_round_sequencer;
    localparam int NL  = 2;
    localparam int TMO = 16;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] key;
    } step_t;

    logic clk = 1'b0;
    logic rst;
    logic [NL-1:0]      start_s, abort_s, ack_s;
    logic [NL-1:0]      req_w, busy_w, done_w, err_w;
    logic [NL-1:0][1:0] sel_w;
    logic [NL-1:0][3:0] key_w;

    int    checks = 0;
    int    errors = 0;
    step_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        aes_round_sequencer_if bus ();

        aes_round_sequencer #(
            .NUM_ROUNDS     ((g == 0) ? 10 : 14),
            .TIMEOUT_CYCLES (TMO)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_s[g]),
            .abort    (abort_s[g]),
            .step_bus (bus.master),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .err      (err_w[g])
        );

        assign bus.step_ack = ack_s[g];
        assign req_w[g]     = bus.step_req;
        assign sel_w[g]     = bus.step_sel;
        assign key_w[g]     = bus.key_idx;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int ln);
        check_eq({tag, "_req"}, req_w[ln], 0);
        check_eq({tag, "_busy"}, busy_w[ln], 0);
        check_eq({tag, "_done"}, done_w[ln], 0);
        check_eq({tag, "_err"}, err_w[ln], 0);
        check_eq({tag, "_selkey"}, {sel_w[ln], key_w[ln]}, 0);
    endtask

    // One encryption on lane ln. dmax: ack delay 1..dmax cycles after the first REQ cycle.
    // abort_at / hold_at / rst_key < 0 disable the abort, withheld-ack and reset scenarios.
    task automatic run_seq(input int ln, input int nr, input int dmax, input bit xstart,
                           input int abort_at, input int hold_at, input int rst_key);
        int    step, reqcyc, dly, mc_cnt, prev_key, ndone, done_t, rise_t, abort_t;
        bit    stop, full;
        step_t got, want, first_v;

        full = (abort_at < 0) && (hold_at < 0) && (rst_key < 0);
        exp_q.delete();
        exp_q.push_back(step_t'{2'd0, 4'd0});
        for (int r = 1; r <= nr; r++) begin
            exp_q.push_back(step_t'{2'd1, 4'(r)});
            exp_q.push_back(step_t'{2'd2, 4'(r)});
            if (r < nr) exp_q.push_back(step_t'{2'd3, 4'(r)});
            exp_q.push_back(step_t'{2'd0, 4'(r)});
        end

        @(negedge clk);
        start_s[ln] = 1'b1;
        @(negedge clk);
        start_s[ln] = 1'b0;
        check_eq("start_busy", busy_w[ln], 1);

        step = 0; reqcyc = 0; dly = 1; mc_cnt = 0; prev_key = 0; ndone = 0;
        done_t = -1; rise_t = 0; abort_t = -1; stop = 1'b0; first_v = '0;
        for (int t = 0; t < 4000 && !stop; t++) begin
            if (t > 0) @(negedge clk);
            ack_s[ln]   = 1'b0;
            abort_s[ln] = 1'b0;
            start_s[ln] = 1'b0;
            if (abort_t >= 0 && t == abort_t + 1) check_idle("abort", ln);
            if (done_w[ln]) begin
                ndone++;
                done_t = t;
                check_eq("done_err", err_w[ln], (hold_at >= 0) ? 1 : 0);
                check_eq("done_busy", busy_w[ln], 0);
            end else if (req_w[ln]) begin
                reqcyc++;
                if (reqcyc == 1) begin
                    rise_t  = t;
                    dly     = (dmax <= 1) ? 1 : int'($urandom_range(dmax, 1));
                    first_v = {sel_w[ln], key_w[ln]};
                    if (xstart && (step == 5 || step == 20)) start_s[ln] = 1'b1;
                end
                if (rst_key >= 0 && reqcyc == 1 && key_w[ln] == 4'(rst_key)) begin
                    rst = 1'b0;
                    #1;
                    check_idle("rst_async", ln);
                    @(negedge clk);
                    rst = 1'b1;
                    repeat (4) @(negedge clk);
                    check_idle("rst_hold", ln);
                    stop = 1'b1;
                end else if (step != hold_at && reqcyc == 1 + dly) begin
                    ack_s[ln] = 1'b1;
                    if (step == abort_at) begin
                        abort_s[ln] = 1'b1;
                        abort_t     = t;
                    end
                    got = {sel_w[ln], key_w[ln]};
                    check_eq("req_stable", got, first_v);
                    if (exp_q.size() == 0) begin
                        check_eq("sb_extra_step", got, 6'h3f);
                    end else begin
                        want = exp_q.pop_front();
                        check_eq("step_selkey", got, want);
                    end
                    check_eq("key_mono", (int'(key_w[ln]) >= prev_key) ? 1 : 0, 1);
                    prev_key = int'(key_w[ln]);
                    if (sel_w[ln] == 2'd3) mc_cnt++;
                    step++;
                end
            end else begin
                reqcyc = 0;
            end
            if (done_t >= 0 && t >= done_t + 4) stop = 1'b1;
            if (abort_t >= 0 && t >= abort_t + 6) stop = 1'b1;
        end
        ack_s[ln]   = 1'b0;
        abort_s[ln] = 1'b0;
        start_s[ln] = 1'b0;
        if (!stop) check_eq("cycle_budget", 0, 1);

        check_eq("done_count", ndone, (abort_at >= 0 || rst_key >= 0) ? 0 : 1);
        if (full) begin
            check_eq("sb_empty", exp_q.size(), 0);
            check_eq("mc_count", mc_cnt, nr - 1);
            if (dmax <= 1) check_eq("done_time", done_t, 12 * nr);
        end
        if (hold_at >= 0) check_eq("tmo_time", done_t - rise_t, TMO);
    endtask

    initial begin
        start_s = '0;
        abort_s = '0;
        ack_s   = '0;
        rst     = 1'b1;
        #2 rst  = 1'b0;
        repeat (3) @(negedge clk);
        for (int ln = 0; ln < NL; ln++) check_idle("reset", ln);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int ln = 0; ln < NL; ln++) check_idle("post_reset", ln);

        run_seq(0, 10, 1, 1'b0, -1, -1, -1);
        run_seq(1, 14, 7, 1'b0, -1, -1, -1);
        run_seq(0, 10, 1, 1'b1, -1, -1, -1);
        run_seq(0, 10, 1, 1'b0, 11, -1, -1);
        run_seq(0, 10, 1, 1'b0, -1, -1, -1);
        run_seq(0, 10, 2, 1'b0, -1, -1, 6);
        run_seq(1, 14, 1, 1'b0, -1, -1, -1);
`ifdef AES_STEP_TIMEOUT_EN
        run_seq(0, 10, 1, 1'b0, -1, 2, -1);
        run_seq(0, 10, 1, 1'b0, -1, -1, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
